systolic_mm_nxn: RTL and testbench

- Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B.
- Operands are latched whole from flat buses on START.
- An internal sequencer generates the diagonal input skew for the left column and top row of processing elements (PEs). A values flow right and B values flow down through the PE grid.
- It is the general-width, general-size, signed-capable successor of the fixed 3×3 8-bit array, with BUSY/DONE handshake and result hold.

---
 rtl/systolic_mm_nxn.sv | 189 ++++++++++++++++++
 tb/tb_systolic_mm_nxn.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_nxn.sv
// -----------------------------------------------------------------------------
// systolic_mm_nxn
//   Output-stationary N x N systolic matrix multiplier, C = A * B.
//   A and B are latched whole on an accepted START. A sequencer then feeds the
//   left column with skewed rows of A and the top row with skewed columns of B.
//   A values hop right and B values hop down, one register per PE. Each PE
//   keeps its own accumulator, and C_FLAT is driven directly from those
//   accumulators.
//
// Ports
//   CLK     in   clock, rising edge
//   RESET   in   synchronous, active-high reset (has priority over START)
//   START   in   job request, sampled only in IDLE or DONE
//   A_FLAT  in   N*N*DW  matrix A, row-major, A[i][k] at [(i*N+k)*DW +: DW]
//   B_FLAT  in   N*N*DW  matrix B, row-major, same packing
//   C_FLAT  out  N*N*AW  result, row-major, C[i][j] at [(i*N+j)*AW +: AW]
//   BUSY    out  high while a job is in flight (FEED or DRAIN)
//   DONE    out  one-cycle pulse. C_FLAT is final from this cycle until the
//                next accepted START or RESET.
// -----------------------------------------------------------------------------
module systolic_mm_nxn #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int AW     = 2*DW+4,
    parameter int SIGNED = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [N*N*DW-1:0]     A_FLAT,
    input  logic [N*N*DW-1:0]     B_FLAT,
    output logic [N*N*AW-1:0]     C_FLAT,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    localparam int              KW     = $clog2(3*N);
    localparam logic [KW-1:0]   K_LAST = KW'(3*N-3);

    state_t            state, state_next;
    logic [KW-1:0]     step;
    logic              accept;

    logic [DW-1:0]     a_op [N][N];
    logic [DW-1:0]     b_op [N][N];
    logic [DW-1:0]     a_edge [N];
    logic [DW-1:0]     b_edge [N];
    logic [DW-1:0]     a_next_edge [N];
    logic [DW-1:0]     b_next_edge [N];

    // Operand presented to each PE, and the forwarded copies. The last column
    // has no right neighbour and the last row no lower neighbour, so those
    // forwarding registers do not exist.
    logic [DW-1:0]     a_in  [N][N];
    logic [DW-1:0]     b_in  [N][N];
    logic [DW-1:0]     a_out [N][N-1];
    logic [DW-1:0]     b_out [N-1][N];

    // Extending both operands to AW bits before multiplying gives the
    // product modulo 2^AW. This matches the sign- or zero-extended
    // 2*DW-bit product for both signed and unsigned modes.
    function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [AW-1:0] ax;
        logic [AW-1:0] bx;
        ax = {{(AW-DW){(SIGNED != 0) && a[DW-1]}}, a};
        bx = {{(AW-DW){(SIGNED != 0) && b[DW-1]}}, b};
        return ax * bx;
    endfunction

    assign accept = START && ((state == S_IDLE) || (state == S_DONE));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (START) state_next = S_FEED;
            S_FEED:  if (step == K_LAST) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = START ? S_FEED : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY = (state == S_FEED) || (state == S_DRAIN);
        DONE = (state == S_DONE);
    end

    // Operand capture. These are plain data registers: they are only read
    // while a job accepted after the capture is running.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_op[i][k] <= A_FLAT[(i*N+k)*DW +: DW];
                    b_op[i][k] <= B_FLAT[(i*N+k)*DW +: DW];
                end
            end
        end
    end

    // Diagonal skew. At step k, row i takes A[i][k-i] and column j takes
    // B[k-j][j]. An index outside 0..N-1 injects zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_next_edge[i] = '0;
            b_next_edge[i] = '0;
            for (int m = 0; m < N; m++) begin
                if (int'(step) == i + m) begin
                    a_next_edge[i] = a_op[i][m];
                    b_next_edge[i] = b_op[m][i];
                end
            end
        end
    end

    // Step counter and edge registers. The edge registers are cleared on
    // accept, so the first busy edge multiplies zeros.
    always_ff @(posedge CLK) begin
        if (RESET || accept) begin
            step <= '0;
            for (int i = 0; i < N; i++) begin
                a_edge[i] <= '0;
                b_edge[i] <= '0;
            end
        end else if (state == S_FEED) begin
            step <= step + 1'b1;
            for (int i = 0; i < N; i++) begin
                a_edge[i] <= a_next_edge[i];
                b_edge[i] <= b_next_edge[i];
            end
        end
    end

    // ---------------- PE grid ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [AW-1:0] acc;

            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_edge[gi];
            end else begin : g_a_hop
                assign a_in[gi][gj] = a_out[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_edge[gj];
            end else begin : g_b_hop
                assign b_in[gi][gj] = b_out[gi-1][gj];
            end

            always_ff @(posedge CLK) begin
                if (RESET || accept) acc <= '0;
                else if (BUSY)       acc <= acc + mul_ext(a_in[gi][gj], b_in[gi][gj]);
            end

            if (gj < N-1) begin : g_a_fwd
                logic [DW-1:0] a_reg;
                always_ff @(posedge CLK) begin
                    if (RESET || accept) a_reg <= '0;
                    else if (BUSY)       a_reg <= a_in[gi][gj];
                end
                assign a_out[gi][gj] = a_reg;
            end

            if (gi < N-1) begin : g_b_fwd
                logic [DW-1:0] b_reg;
                always_ff @(posedge CLK) begin
                    if (RESET || accept) b_reg <= '0;
                    else if (BUSY)       b_reg <= b_in[gi][gj];
                end
                assign b_out[gi][gj] = b_reg;
            end

            assign C_FLAT[(gi*N+gj)*AW +: AW] = acc;
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
module tb_systolic_mm_nxn;

    logic          clk;
    logic          rst;
    logic          start3;
    logic [71:0]   a3, b3;
    logic [179:0]  cu, cs;
    logic [143:0]  cw;
    logic          busy_u, done_u, busy_s, done_s, busy_w, done_w;
    logic          start4;
    logic [63:0]   a4, b4;
    logic [191:0]  c4;
    logic          busy4, done4;

    int total = 0;
    int bad   = 0;

    systolic_mm_nxn #(.N(3), .DW(8), .AW(20), .SIGNED(0)) u_u (
        .CLK(clk), .RESET(rst), .START(start3), .A_FLAT(a3), .B_FLAT(b3),
        .C_FLAT(cu), .BUSY(busy_u), .DONE(done_u));
    systolic_mm_nxn #(.N(3), .DW(8), .AW(20), .SIGNED(1)) u_s (
        .CLK(clk), .RESET(rst), .START(start3), .A_FLAT(a3), .B_FLAT(b3),
        .C_FLAT(cs), .BUSY(busy_s), .DONE(done_s));
    systolic_mm_nxn #(.N(3), .DW(8), .AW(16), .SIGNED(0)) u_w (
        .CLK(clk), .RESET(rst), .START(start3), .A_FLAT(a3), .B_FLAT(b3),
        .C_FLAT(cw), .BUSY(busy_w), .DONE(done_w));
    systolic_mm_nxn #(.N(4), .DW(4), .AW(12), .SIGNED(0)) u_4 (
        .CLK(clk), .RESET(rst), .START(start4), .A_FLAT(a4), .B_FLAT(b4),
        .C_FLAT(c4), .BUSY(busy4), .DONE(done4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] fill3(input logic [7:0] v);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [71:0] ident3(input logic [7:0] s);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) r[(i*3+i)*8 +: 8] = s;
        return r;
    endfunction

    function automatic logic [71:0] seq3(input int s);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'((i+1)*s);
        return r;
    endfunction

    function automatic logic [191:0] mm4(input logic [63:0] a, input logic [63:0] b);
        logic [191:0] r;
        logic [11:0]  acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + 12'(a[(i*4+k)*4 +: 4]) * 12'(b[(k*4+j)*4 +: 4]);
                r[(i*4+j)*12 +: 12] = acc;
            end
        end
        return r;
    endfunction

    // Pulse START for one accept edge on the N=3 group and wait for DONE;
    // BUSY must stay high on every sample before DONE.
    task automatic run3(input logic [71:0] a, input logic [71:0] b, output int lat);
        a3 = a; b3 = b; start3 = 1'b1;
        step();
        start3 = 1'b0;
        lat = 0;
        chk("busy_after_accept", 192'(busy_u), 192'(1));
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done_u) begin
                lat = c;
                break;
            end
            chk("busy_in_job", 192'(busy_u), 192'(1));
        end
    endtask

    task automatic run4(input logic [63:0] a, input logic [63:0] b, output int lat);
        a4 = a; b4 = b; start4 = 1'b1;
        step();
        start4 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done4) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic seen;
        logic [63:0] ra, rb;

        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
        a3 = '0; b3 = '0; a4 = '0; b4 = '0;
        step(); step();
        rst = 1'b0;

        // Reset state.
        chk("rst_c_u", 192'(cu), 192'(0));
        chk("rst_c_4", c4, 192'(0));
        chk("rst_busy", 192'({busy_u, busy_s, busy_w, busy4}), 192'(0));
        chk("rst_done", 192'({done_u, done_s, done_w, done4}), 192'(0));

        // Identity times [1..9].
        run3(ident3(8'd1), seq3(1), lat);
        chk("id_latency", 192'(lat), 192'(8));
        chk("id_done_all", 192'({done_s, done_w}), 192'(2'b11));
        for (int i = 0; i < 9; i++) chk("id_c", 192'(cu[i*20 +: 20]), 192'(i+1));
        chk("id_signed_c4", 192'(cs[4*20 +: 20]), 192'(5));
        step();
        chk("id_done_pulse", 192'(done_u), 192'(0));
        chk("id_busy_after", 192'(busy_u), 192'(0));
        step(); step();
        chk("id_hold", 192'(cu[8*20 +: 20]), 192'(9));

        // All 255: no wrap at AW=20, wraps at AW=16, signed -1*-1*3 = 3.
        run3(fill3(8'hFF), fill3(8'hFF), lat);
        chk("ff_latency", 192'(lat), 192'(8));
        chk("ff_c_u0", 192'(cu[0 +: 20]), 192'(195075));
        chk("ff_c_u8", 192'(cu[8*20 +: 20]), 192'(195075));
        chk("ff_c_w0", 192'(cw[0 +: 16]), 192'(64003));
        chk("ff_c_w5", 192'(cw[5*16 +: 16]), 192'(64003));
        chk("ff_c_s3", 192'(cs[3*20 +: 20]), 192'(3));
        step();
        chk("ff_done_pulse", 192'(done_u), 192'(0));

        // Most negative operands in signed mode.
        run3(fill3(8'h80), fill3(8'h80), lat);
        chk("neg_c_s0", 192'(cs[0 +: 20]), 192'(49152));
        chk("neg_c_s7", 192'(cs[7*20 +: 20]), 192'(49152));
        chk("neg_c_u2", 192'(cu[2*20 +: 20]), 192'(49152));
        step();

        // Mixed sign: 2 * -3 summed three times = -18.
        run3(fill3(8'd2), fill3(8'hFD), lat);
        chk("mix_c_s0", 192'(cs[0 +: 20]), 192'(20'hFFFEE));
        chk("mix_c_s8", 192'(cs[8*20 +: 20]), 192'(20'hFFFEE));
        chk("mix_c_u1", 192'(cu[1*20 +: 20]), 192'(1518));
        step();

        // Back-to-back: START held through the DONE cycle with new operands.
        a3 = ident3(8'd1); b3 = seq3(1); start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int c = 1; c <= 7; c++) step();
        chk("b2b_pre_done", 192'(done_u), 192'(0));
        step();
        chk("b2b_first_done", 192'(done_u), 192'(1));
        chk("b2b_first_c", 192'(cu[4*20 +: 20]), 192'(5));
        a3 = ident3(8'd2); start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("b2b_done_drop", 192'(done_u), 192'(0));
        chk("b2b_busy", 192'(busy_u), 192'(1));
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done_u) begin
                lat = c;
                break;
            end
        end
        chk("b2b_latency", 192'(lat), 192'(8));
        for (int i = 0; i < 9; i++) chk("b2b_c", 192'(cu[i*20 +: 20]), 192'(2*(i+1)));
        step();

        // START pulsed while busy is ignored.
        a3 = ident3(8'd1); b3 = seq3(1); start3 = 1'b1;
        step();
        start3 = 1'b0;
        step(); step();
        a3 = fill3(8'hFF); b3 = fill3(8'hFF); start3 = 1'b1;
        step();
        start3 = 1'b0;
        lat = 3;
        for (int c = 4; c <= 20; c++) begin
            step();
            if (done_u) begin
                lat = c;
                break;
            end
        end
        chk("ign_latency", 192'(lat), 192'(8));
        chk("ign_c0", 192'(cu[0 +: 20]), 192'(1));
        chk("ign_c8", 192'(cu[8*20 +: 20]), 192'(9));
        step();

        // RESET at cycle 4 of a job aborts it.
        a3 = fill3(8'hFF); b3 = fill3(8'hFF); start3 = 1'b1;
        step();
        start3 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_c", 192'(cu), 192'(0));
        chk("abort_busy", 192'(busy_u), 192'(0));
        chk("abort_done", 192'(done_u), 192'(0));
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done_u) seen = 1'b1;
        end
        chk("abort_no_done", 192'(seen), 192'(0));

        // N=4, DW=4 random jobs against the reference model.
        for (int t = 0; t < 50; t++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run4(ra, rb, lat);
            chk("n4_latency", 192'(lat), 192'(11));
            chk("n4_c", c4, mm4(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
